// File: rtl/lsu_ctrl.sv
// Load/store unit for the RV32I single-cycle core: drives a req/ack data-memory port from the
// ALU effective address, lane-replicates stores, extends loads and stalls the core until done.
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        lsu_done,
    output logic        lsu_misalign,
    output logic        lsu_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{sd[7:0]}};
            2'b01:   wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] lane;
        logic [31:0] res;
        lane = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{lane[7]}}, lane[7:0]};
            3'b001:  res = {{16{lane[15]}}, lane[15:0]};
            3'b100:  res = {24'h000000, lane[7:0]};
            3'b101:  res = {16'h0000, lane[15:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic start;
    logic illegal;
    logic misalign;
    logic go;

    // Decode legality and alignment of the instruction presented in IDLE.
    always_comb begin
        start    = lsu_valid & (mem_read | mem_write);
        illegal  = 1'b0;
        misalign = 1'b0;
        if (mem_read & mem_write) begin
            illegal = 1'b1;
        end else if (mem_read) begin
            illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
        end else begin
            illegal = (funct3[2] == 1'b1) | (funct3[1:0] == 2'b11);
        end
        if (!illegal) begin
            case (funct3[1:0])
                2'b01:   misalign = addr[0];
                2'b10:   misalign = (addr[1:0] != 2'b00);
                default: misalign = 1'b0;
            endcase
        end else begin
            misalign = 1'b0;
        end
        go = start & ~illegal & ~misalign;
    end

    // Status outputs; the early stall and decode pulses must be visible in the issuing cycle.
    always_comb begin
        lsu_stall    = ((state_q == ST_IDLE) & go) | (state_q == ST_REQ);
        lsu_done     = (state_q == ST_DONE);
        lsu_misalign = (state_q == ST_IDLE) & start & ~illegal & misalign;
        lsu_err      = ((state_q == ST_IDLE) & start & illegal) | ((state_q == ST_DONE) & err_q);
    end

    // Access FSM with the registered memory port and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0000_0000;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0000_0000;
            load_data  <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (go) begin
                        state_q    <= ST_REQ;
                        cnt_q      <= '0;
                        f3_q       <= funct3;
                        off_q      <= addr[1:0];
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= calc_be(funct3, addr[1:0]);
                        dmem_wdata <= calc_wdata(funct3, store_data);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // An ack in the expiry cycle still counts as a normal completion.
                    if (dmem_ack) begin
                        load_data <= load_ext(f3_q, off_q, dmem_rdata);
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        err_q     <= 1'b0;
                        state_q   <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        load_data <= 32'h0000_0000;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a hand-driven data-memory responder.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        lsu_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        lsu_stall;
    logic [31:0] load_data;
    logic        lsu_done;
    logic        lsu_misalign;
    logic        lsu_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int checks;
    int errors;

    lsu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_valid    (lsu_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .lsu_stall    (lsu_stall),
        .load_data    (load_data),
        .lsu_done     (lsu_done),
        .lsu_misalign (lsu_misalign),
        .lsu_err      (lsu_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
        lsu_valid  = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    // Runs one accepted access; ack_cyc is the REQ-cycle index carrying the ack (-1 = never).
    task automatic do_access(input int ack_cyc, input logic [31:0] rd,
                             output int stalls, output int reqcyc, output logic done_seen,
                             output logic [31:0] ld, output logic err,
                             output logic [31:0] s_addr, output logic [3:0] s_be,
                             output logic [31:0] s_wdata, output logic s_we);
        stalls    = 0;
        reqcyc    = 0;
        done_seen = 1'b0;
        ld        = 32'h0;
        err       = 1'b0;
        s_addr    = 32'h0;
        s_be      = 4'h0;
        s_wdata   = 32'h0;
        s_we      = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (dmem_req) begin
                if (reqcyc == 0) begin
                    s_addr  = dmem_addr;
                    s_be    = dmem_be;
                    s_wdata = dmem_wdata;
                    s_we    = dmem_we;
                end
                if (reqcyc == ack_cyc) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rd;
                end
                reqcyc++;
            end
            @(negedge clk);
            if (lsu_stall) stalls++;
            if (lsu_done) begin
                done_seen = 1'b1;
                ld        = load_data;
                err       = lsu_err;
            end
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
        end
        lsu_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    int          st;
    int          rc;
    logic        dn;
    logic [31:0] ld;
    logic        er;
    logic [31:0] sa;
    logic [3:0]  sb;
    logic [31:0] sw;
    logic        swe;

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        lsu_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        dmem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_be", {28'h0, dmem_be}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_flags", {28'h0, lsu_stall, lsu_done, lsu_err, lsu_misalign}, 32'h0);
        @(posedge clk);
        #1;

        // LW 0x100, ack in third REQ cycle
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        do_access(2, 32'hDEADBEEF, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("lw_addr", sa, 32'h0000_0100);
        chk("lw_be", {28'h0, sb}, 32'hF);
        chk("lw_we", {31'h0, swe}, 32'h0);
        chk("lw_stalls", st, 32'd4);
        chk("lw_done", {31'h0, dn}, 32'h1);
        chk("lw_data", ld, 32'hDEADBEEF);
        chk("lw_err", {31'h0, er}, 32'h0);

        // LB / LBU 0x103
        set_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        do_access(0, 32'h80FF_0000, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("lb_be", {28'h0, sb}, 32'h8);
        chk("lb_data", ld, 32'hFFFFFF80);
        chk("lb_stalls", st, 32'd2);
        set_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
        do_access(1, 32'h80FF_0000, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("lbu_data", ld, 32'h00000080);

        // LH / LHU 0x102
        set_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
        do_access(0, 32'h80FF_0000, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("lh_be", {28'h0, sb}, 32'hC);
        chk("lh_data", ld, 32'hFFFF80FF);
        set_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0);
        do_access(0, 32'h80FF_0000, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("lhu_data", ld, 32'h000080FF);

        // SH 0x202 and SB 0x101
        set_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234ABCD);
        do_access(0, 32'h0, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("sh_we", {31'h0, swe}, 32'h1);
        chk("sh_be", {28'h0, sb}, 32'hC);
        chk("sh_wdata", sw, 32'hABCDABCD);
        chk("sh_addr", sa, 32'h0000_0200);
        chk("sh_done", {31'h0, dn}, 32'h1);
        set_op(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000005A);
        do_access(0, 32'h0, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("sb_be", {28'h0, sb}, 32'h2);
        chk("sb_wdata", sw, 32'h5A5A5A5A);

        // Misaligned LH and illegal ops: pulses only, no bus cycle
        set_op(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0);
        @(negedge clk);
        chk("mis_flags", {29'h0, lsu_misalign, lsu_err, lsu_stall}, 32'h4);
        @(posedge clk);
        #1;
        chk("mis_noreq", {31'h0, dmem_req}, 32'h0);
        set_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        @(negedge clk);
        chk("ill_ld_flags", {29'h0, lsu_misalign, lsu_err, lsu_stall}, 32'h2);
        @(posedge clk);
        #1;
        chk("ill_ld_noreq", {31'h0, dmem_req}, 32'h0);
        set_op(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0);
        @(negedge clk);
        chk("ill_st_flags", {29'h0, lsu_misalign, lsu_err, lsu_stall}, 32'h2);
        set_op(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0);
        @(negedge clk);
        chk("ill_rw_flags", {29'h0, lsu_misalign, lsu_err, lsu_stall}, 32'h2);
        @(posedge clk);
        #1;
        chk("ill_rw_noreq", {31'h0, dmem_req}, 32'h0);
        lsu_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;

        // Timeout, then ack exactly in the expiry cycle
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        do_access(-1, 32'h0, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("to_reqcyc", rc, 32'd16);
        chk("to_stalls", st, 32'd17);
        chk("to_done", {31'h0, dn}, 32'h1);
        chk("to_err", {31'h0, er}, 32'h1);
        chk("to_data", ld, 32'h0);
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        do_access(15, 32'h11223344, st, rc, dn, ld, er, sa, sb, sw, swe);
        chk("exp_reqcyc", rc, 32'd16);
        chk("exp_err", {31'h0, er}, 32'h0);
        chk("exp_data", ld, 32'h11223344);

        // Reset in REQ, then a late ack
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        @(posedge clk);
        #1;
        chk("rr_req_up", {31'h0, dmem_req}, 32'h1);
        #2;
        rst       = 1'b1;
        lsu_valid = 1'b0;
        mem_read  = 1'b0;
        #1;
        chk("rr_req_async", {31'h0, dmem_req}, 32'h0);
        chk("rr_stall", {31'h0, lsu_stall}, 32'h0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rr_flags", {29'h0, lsu_done, lsu_stall, dmem_req}, 32'h0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("rr_load", load_data, 32'h0);
        chk("rr_nodone", {31'h0, lsu_done}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
